// File: rtl/sd_block_write_pkg.sv
// Shared definitions for the SD block-write data path: FSM states, framing
// constants and the error codes also used by the command executor.
package sd_block_write_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_RWAIT,
    ST_RESP,
    ST_BUSY
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK           = 2'b00,
    ERR_REJECTED     = 2'b01,
    ERR_RESP_TIMEOUT = 2'b10,
    ERR_BUSY_TIMEOUT = 2'b11
  } err_e;

  localparam logic [7:0]  START_TOKEN   = 8'hFE;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [2:0]  RESP_ACCEPTED = 3'b010;

endpackage

// File: rtl/sd_block_write_crc16.sv
// Serial CRC16-CCITT (x^16+x^12+x^5+1, init 0), one bit per enabled cycle.
module sd_crc16_serial
  import sd_block_write_pkg::*;
(
  input  logic        clk400,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[15] ^ bit_in;
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_block_write.sv
// SPI-mode single-block write: frames idle/token/512 data bytes/CRC16 onto SDout,
// then collects the card's data-response token and waits out the busy phase.
module sd_block_write
  import sd_block_write_pkg::*;
#(
  parameter int unsigned PRE_BITS     = 8,
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned BUSY_TIMEOUT = 65535
) (
  input  logic        clk400,
  input  logic        reset,
  input  logic        start,
  input  logic        SDin,
  output logic        SDout,
  output logic [7:0]  casheAddress,
  input  logic [15:0] casheValue,
  output logic        ready,
  output logic        done,
  output logic [2:0]  respStatus,
  output logic [1:0]  errCode
);

  localparam logic [11:0] PRE_LAST  = 12'(PRE_BITS - 1);
  localparam logic [15:0] RESP_LAST = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  resp_sh_q, resp_sh_d;
  logic [7:0]  addr_q, addr_d;
  logic [2:0]  resp_status_q, resp_status_d;
  err_e        err_q, err_d;
  logic        done_q, done_d;

  logic        sd_out;
  logic        crc_clear, crc_en;
  logic [15:0] crc;

  sd_crc16_serial u_crc (
    .clk400 (clk400),
    .reset  (reset),
    .clear  (crc_clear),
    .en     (crc_en),
    .bit_in (sd_out),
    .crc    (crc)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    shift_d       = shift_q;
    resp_sh_d     = resp_sh_q;
    addr_d        = addr_q;
    resp_status_d = resp_status_q;
    err_d         = err_q;
    done_d        = 1'b0;
    crc_clear     = 1'b0;
    crc_en        = 1'b0;
    sd_out        = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        crc_clear = 1'b1;
        addr_d    = '0;
        if (start) begin
          state_d       = ST_PRE;
          cnt_d         = '0;
          err_d         = ERR_OK;
          resp_status_d = '0;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_TOKEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_TOKEN: begin
        sd_out = START_TOKEN[~cnt_q[2:0]];
        // word 0 is fetched during the token so DATA starts with it in place
        if (cnt_q[2:0] == 3'd7) begin
          shift_d = casheValue;
          addr_d  = addr_q + 8'd1;
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_DATA: begin
        sd_out = shift_q[15];
        crc_en = 1'b1;
        if (cnt_q == 12'hFFF) begin
          state_d = ST_CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
          // last bit of words 0..254 reloads; the final load wraps the address to 0
          if (cnt_q[3:0] == 4'hF) begin
            shift_d = casheValue;
            addr_d  = addr_q + 8'd1;
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
      end
      ST_CRC: begin
        sd_out = crc[~cnt_q[3:0]];
        if (cnt_q[3:0] == 4'hF) begin
          state_d = ST_RWAIT;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_RWAIT: begin
        if (!SDin) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else if (tmo_q >= RESP_LAST) begin
          state_d = ST_IDLE;
          err_d   = ERR_RESP_TIMEOUT;
          done_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_RESP: begin
        resp_sh_d = {resp_sh_q[1:0], SDin};
        // fourth bit is the end bit; status is the three already shifted in
        if (cnt_q[1:0] == 2'd3) begin
          resp_status_d = resp_sh_q;
          err_d         = (resp_sh_q == RESP_ACCEPTED) ? ERR_OK : ERR_REJECTED;
          state_d       = ST_BUSY;
          tmo_d         = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_BUSY: begin
        if (SDin) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tmo_q >= BUSY_LAST) begin
          state_d = ST_IDLE;
          err_d   = ERR_BUSY_TIMEOUT;
          done_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tmo_q         <= '0;
      shift_q       <= '0;
      resp_sh_q     <= '0;
      addr_q        <= '0;
      resp_status_q <= '0;
      err_q         <= ERR_OK;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      shift_q       <= shift_d;
      resp_sh_q     <= resp_sh_d;
      addr_q        <= addr_d;
      resp_status_q <= resp_status_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  assign SDout        = sd_out;
  assign casheAddress = addr_q;
  assign ready        = (state_q == ST_IDLE);
  assign done         = done_q;
  assign respStatus   = resp_status_q;
  assign errCode      = err_q;

endmodule

// File: tb/tb_sd_block_write.sv
// Directed bench for sd_block_write: byte/address scoreboard on the outgoing
// frame, scripted card responses, and done/status checks per transfer.
module tb_sd_block_write;

  localparam int PRE_BITS     = 8;
  localparam int RESP_TIMEOUT = 64;
  localparam int BUSY_TIMEOUT = 32;
  localparam int FRAME_BITS   = PRE_BITS + 8 + 4096 + 16;

  logic        clk400 = 1'b0;
  logic        reset;
  logic        start;
  logic        SDin;
  logic        SDout;
  logic [7:0]  casheAddress;
  logic [15:0] casheValue;
  logic        ready;
  logic        done;
  logic [2:0]  respStatus;
  logic [1:0]  errCode;

  logic [15:0] mem [256];
  logic [7:0]  exp_q[$];
  logic [7:0]  addr_exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  sd_block_write #(
    .PRE_BITS    (PRE_BITS),
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk400      (clk400),
    .reset       (reset),
    .start       (start),
    .SDin        (SDin),
    .SDout       (SDout),
    .casheAddress(casheAddress),
    .casheValue  (casheValue),
    .ready       (ready),
    .done        (done),
    .respStatus  (respStatus),
    .errCode     (errCode)
  );

  always #5 clk400 = ~clk400;

  // block cache with one-cycle read latency
  always @(posedge clk400) casheValue <= mem[casheAddress];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16_model(input logic [7:0] bytes[$]);
    logic [15:0] c = 16'h0000;
    logic        fb;
    foreach (bytes[k]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ bytes[k][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // one transfer; card script = lead ones, start 0, status, end 1, busy zeros, then 1
  task automatic xfer(input bit keep_start, input int lead, input logic [2:0] status,
                      input int busy, input bit busy_stuck, input bit no_resp,
                      input bit crc_literal, input int reset_at, input bit pulse_start);
    logic [7:0]  data_bytes[$];
    logic [15:0] crc_exp;
    logic [7:0]  byte_acc;
    logic [7:0]  exp_byte;
    int          done_idx;
    int          found_j;
    logic [1:0]  err_exp;
    logic [2:0]  stat_exp;
    bit          sdout_high;
    logic        cb;

    for (int w = 0; w < 256; w++) begin
      data_bytes.push_back(mem[w][15:8]);
      data_bytes.push_back(mem[w][7:0]);
      addr_exp_q.push_back(8'(w + 1));
    end
    for (int k = 0; k < PRE_BITS / 8; k++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    foreach (data_bytes[k]) exp_q.push_back(data_bytes[k]);
    if (crc_literal) crc_exp = 16'h7FA1;
    else             crc_exp = crc16_model(data_bytes);
    exp_q.push_back(crc_exp[15:8]);
    exp_q.push_back(crc_exp[7:0]);

    if (no_resp) begin
      done_idx = RESP_TIMEOUT; err_exp = 2'b10; stat_exp = 3'b000;
    end else if (busy_stuck) begin
      done_idx = lead + 5 + BUSY_TIMEOUT; err_exp = 2'b11; stat_exp = status;
    end else begin
      done_idx = lead + busy + 6; stat_exp = status;
      err_exp  = (status == 3'b010) ? 2'b00 : 2'b01;
    end

    SDin  = 1'b1;
    start = 1'b1;
    @(negedge clk400);
    if (!keep_start) start = 1'b0;
    byte_acc = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i == 0) begin
        check("ready_busy", ready, 1'b0);
        check("done_low", done, 1'b0);
      end
      if (i >= PRE_BITS + 8 && i < PRE_BITS + 8 + 4096 && ((i - PRE_BITS - 8) % 16) == 0) begin
        if (addr_exp_q.size() > 0) check("cache_addr", casheAddress, addr_exp_q.pop_front());
      end
      byte_acc = {byte_acc[6:0], SDout};
      if ((i % 8) == 7) begin
        exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check("frame_byte", byte_acc, exp_byte);
      end
      if (pulse_start && i == 2000) start = 1'b1;
      if (pulse_start && i == 2001) start = 1'b0;
      if (i == reset_at) begin
        reset = 1'b1;
        #1;
        check("rst_sdout", SDout, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_addr", casheAddress, 8'h00);
        @(negedge clk400);
        reset = 1'b0;
        exp_q.delete();
        addr_exp_q.delete();
        return;
      end
      @(negedge clk400);
    end

    found_j    = -1;
    sdout_high = 1'b1;
    for (int j = 0; j <= done_idx + 8; j++) begin
      if (done) begin
        found_j = j;
        break;
      end
      if (SDout !== 1'b1) sdout_high = 1'b0;
      if (no_resp || j < lead)    cb = 1'b1;
      else if (j == lead)         cb = 1'b0;
      else if (j <= lead + 3)     cb = status[2 - (j - lead - 1)];
      else if (j == lead + 4)     cb = 1'b1;
      else if (busy_stuck)        cb = 1'b0;
      else if (j < lead + 5 + busy) cb = 1'b0;
      else                        cb = 1'b1;
      SDin = cb;
      if (pulse_start && j == lead + 5) start = 1'b1;
      if (pulse_start && j == lead + 6) start = 1'b0;
      @(negedge clk400);
    end
    SDin = 1'b1;
    check("done_time", found_j, done_idx);
    check("idle_sdout_high", sdout_high, 1'b1);
    check("ready_at_done", ready, 1'b1);
    check("err_code", errCode, err_exp);
    check("resp_status", respStatus, stat_exp);
    if (!keep_start) begin
      @(negedge clk400);
      check("done_one_cycle", done, 1'b0);
      check("ready_idle", ready, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    SDin  = 1'b1;
    for (int w = 0; w < 256; w++) mem[w] = 16'hFFFF;
    repeat (3) @(negedge clk400);
    check("reset_sdout", SDout, 1'b1);
    check("reset_addr", casheAddress, 8'h00);
    check("reset_ready", ready, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_status", respStatus, 3'b000);
    check("reset_err", errCode, 2'b00);
    reset = 1'b0;
    @(negedge clk400);

    // all-ones block, accepted, short busy
    xfer(1'b0, 3, 3'b010, 3, 1'b0, 1'b0, 1'b1, -1, 1'b0);

    // ramp block, rejected (0xEB)
    for (int w = 0; w < 256; w++) mem[w] = 16'(w) * 16'h0101;
    xfer(1'b0, 3, 3'b101, 3, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // no response start bit
    xfer(1'b0, 3, 3'b010, 0, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    // accepted then stuck busy
    xfer(1'b0, 3, 3'b010, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // reset during data word 100, then a full clean block
    for (int w = 0; w < 256; w++) mem[w] = ~(16'(w) * 16'h0101);
    xfer(1'b0, 3, 3'b010, 3, 1'b0, 1'b0, 1'b0, PRE_BITS + 8 + 100 * 16 + 1, 1'b0);
    check("post_rst_err", errCode, 2'b00);
    check("post_rst_done", done, 1'b0);
    xfer(1'b0, 3, 3'b010, 3, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // start pulses mid-transfer are ignored; held start chains two frames
    for (int w = 0; w < 256; w++) mem[w] = 16'(w * 16'h3A7 + 16'h1234);
    xfer(1'b0, 2, 3'b010, 5, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    xfer(1'b1, 1, 3'b010, 2, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    xfer(1'b0, 4, 3'b010, 4, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
